// File: rtl/ram_ctrl_pkg.sv
// Shared types and helpers for the RAM self-test sequencer.
package ram_ctrl_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    READ,
    WAIT,
    CHECK,
    SHOW,
    DONE
  } state_e;

  // Every byte of the word carries the zero-extended address, then the seed mask.
  function automatic logic [DATA_W-1:0] pat(input logic [7:0] addr, input logic [DATA_W-1:0] seed);
    return seed ^ {4{addr}};
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Load/expire down-counter pacing how long each LED byte stays on display.
module hold_timer #(
  parameter int HOLD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam int CNT_W = $clog2(HOLD + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(HOLD - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/ram_selftest_ctrl.sv
// Fill / read-back / display sequencer for the single-port data RAM.
//   state | meaning
//   IDLE  | waiting for start after reset
//   FILL  | one pattern write per cycle, address 0..DEPTH-1
//   READ  | read strobe for the current address
//   WAIT  | RAM read latency
//   CHECK | capture read data, compare, record first error
//   SHOW  | step mux through bytes 0..3, HOLD cycles each
//   DONE  | pass complete, last byte stays on the LEDs
module ram_selftest_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int          ADDR_W = 6,
  parameter logic [31:0] SEED   = 32'h0000_0000,
  parameter int          HOLD   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       ram_dout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              mem_write,
  output logic              mem_read,
  output logic [1:0]        mux,
  output logic [7:0]        led,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [1:0]          mux_q, mux_d;
  logic [7:0]          led_q, led_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic [DATA_W-1:0]   expected;
  logic                timer_load;
  logic                timer_expire;

  hold_timer #(.HOLD(HOLD)) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .expire (timer_expire)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    word_d     = word_q;
    mux_d      = mux_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    timer_load = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    mem_din    = '0;
    expected   = pat(8'(addr_q), SEED);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = FILL;
          addr_d     = '0;
          err_d      = 1'b0;
          err_addr_d = '0;
        end
      end
      FILL: begin
        mem_write = 1'b1;
        mem_din   = expected;
        if (addr_q == LAST) begin
          state_d = READ;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      READ: begin
        mem_read = 1'b1;
        state_d  = WAIT;
      end
      WAIT: state_d = CHECK;
      CHECK: begin
        word_d = ram_dout;
        if (ram_dout != expected) begin
          err_d = 1'b1;
          if (!err_q) err_addr_d = addr_q;
        end
        mux_d      = 2'd0;
        timer_load = 1'b1;
        state_d    = SHOW;
      end
      SHOW: begin
        if (timer_expire) begin
          if (mux_q == 2'd3) begin
            if (addr_q == LAST) begin
              state_d = DONE;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = READ;
            end
          end else begin
            mux_d      = mux_q + 2'd1;
            timer_load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Register the byte for the upcoming mux value so led and mux change together.
    led_d = led_q;
    if (state_d == SHOW) led_d = word_d[{mux_d, 3'b000} +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      word_q     <= '0;
      mux_q      <= 2'd0;
      led_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      mux_q      <= mux_d;
      led_q      <= led_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign mem_addr = addr_q;
  assign mux      = mux_q;
  assign led      = led_q;
  assign err      = err_q;
  assign err_addr = err_addr_q;
  assign busy     = (state_q != IDLE) && (state_q != DONE);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_ram_selftest_ctrl.sv
// Self-checking bench: two sequencers on behavioural 1-cycle RAMs with injectable read corruption.
module tb_ram_selftest_ctrl;

  localparam int          ADDR_W = 6;
  localparam int          DEPTH  = 64;
  localparam int          NDUT   = 2;
  localparam int          HOLD0  = 4;
  localparam int          HOLD1  = 1;
  localparam logic [31:0] SEED0  = 32'h0000_0000;
  localparam logic [31:0] SEED1  = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst       [NDUT];
  logic              start     [NDUT];
  logic [31:0]       ram_dout  [NDUT];
  logic [ADDR_W-1:0] mem_addr  [NDUT];
  logic [31:0]       mem_din   [NDUT];
  logic              mem_write [NDUT];
  logic              mem_read  [NDUT];
  logic [1:0]        mux       [NDUT];
  logic [7:0]        led       [NDUT];
  logic              busy      [NDUT];
  logic              done      [NDUT];
  logic              err       [NDUT];
  logic [ADDR_W-1:0] err_addr  [NDUT];

  ram_selftest_ctrl #(.ADDR_W(ADDR_W), .SEED(SEED0), .HOLD(HOLD0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .ram_dout(ram_dout[0]),
    .mem_addr(mem_addr[0]), .mem_din(mem_din[0]), .mem_write(mem_write[0]),
    .mem_read(mem_read[0]), .mux(mux[0]), .led(led[0]), .busy(busy[0]),
    .done(done[0]), .err(err[0]), .err_addr(err_addr[0])
  );

  ram_selftest_ctrl #(.ADDR_W(ADDR_W), .SEED(SEED1), .HOLD(HOLD1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .ram_dout(ram_dout[1]),
    .mem_addr(mem_addr[1]), .mem_din(mem_din[1]), .mem_write(mem_write[1]),
    .mem_read(mem_read[1]), .mux(mux[1]), .led(led[1]), .busy(busy[1]),
    .done(done[1]), .err(err[1]), .err_addr(err_addr[1])
  );

  // RAM model: synchronous write, read data registered one cycle after the strobe.
  logic [31:0] mem  [NDUT][DEPTH];
  logic [31:0] corr [NDUT][DEPTH];

  always @(posedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (mem_write[d]) mem[d][mem_addr[d]] <= mem_din[d];
      if (mem_read[d])  ram_dout[d] <= mem[d][mem_addr[d]] ^ corr[d][mem_addr[d]];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int hold_of(input int d);
    return (d == 0) ? HOLD0 : HOLD1;
  endfunction

  function automatic logic [31:0] seed_of(input int d);
    return (d == 0) ? SEED0 : SEED1;
  endfunction

  function automatic logic [31:0] mpat(input int a, input logic [31:0] seed);
    return seed ^ (32'(a) * 32'h0101_0101);
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int m);
    return 8'(w >> (8 * m));
  endfunction

  function automatic logic [31:0] stored(input int d, input int a);
    return mpat(a, seed_of(d)) ^ corr[d][a];
  endfunction

  task automatic clear_corr(input int d);
    for (int a = 0; a < DEPTH; a++) corr[d][a] = 32'h0;
  endtask

  task automatic check_idle_outputs(input int d, input string tag);
    check({tag, "_strobes"}, {mem_write[d], mem_read[d], busy[d], done[d], err[d]}, 64'h0);
    check({tag, "_addr"}, mem_addr[d], 64'h0);
    check({tag, "_din"}, mem_din[d], 64'h0);
    check({tag, "_led_mux"}, {mux[d], led[d]}, 64'h0);
    check({tag, "_err_addr"}, err_addr[d], 64'h0);
  endtask

  // One full pass from an accepted start to done; expectations come from the timing rules.
  task automatic run_once(input int d, input int show_addr, input int win_lo, input int win_hi);
    int          hold;
    int          pw;
    int          exp_done;
    int          first_bad;
    int          done_s;
    int          err_s;
    int          wr_n, wr_bad, rd_n, rd_bad, both_hi, busy_bad, led_n, led_bad;
    int          base, j;
    logic [31:0] wr_din [DEPTH];
    logic [31:0] sw;
    hold      = hold_of(d);
    pw        = 3 + 4 * hold;
    exp_done  = DEPTH + DEPTH * pw;
    first_bad = -1;
    for (int a = DEPTH - 1; a >= 0; a--) if (corr[d][a] != 32'h0) first_bad = a;
    done_s = -1; err_s = -1;
    wr_n = 0; wr_bad = 0; rd_n = 0; rd_bad = 0; both_hi = 0; busy_bad = 0; led_n = 0; led_bad = 0;
    base = (show_addr >= 0) ? DEPTH + show_addr * pw + 3 : -1000;
    for (int a = 0; a < DEPTH; a++) wr_din[a] = 32'h0;

    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    check("err_cleared_on_start", {err[d], err_addr[d]}, 64'h0);

    for (int s = 0; s <= exp_done + 100; s++) begin
      if (s == win_lo) start[d] = 1'b1;
      if (s == win_hi) start[d] = 1'b0;
      if (mem_write[d]) begin
        if (s != wr_n || int'(mem_addr[d]) != wr_n || mem_din[d] !== mpat(wr_n, seed_of(d))) wr_bad++;
        wr_din[mem_addr[d]] = mem_din[d];
        wr_n++;
      end
      if (mem_read[d]) begin
        if (int'(mem_addr[d]) != rd_n || s != DEPTH + rd_n * pw) rd_bad++;
        rd_n++;
      end
      if (mem_write[d] && mem_read[d]) both_hi++;
      if (err[d] && err_s < 0) err_s = s;
      if (s >= base && s < base + 4 * hold) begin
        j  = (s - base) / hold;
        sw = stored(d, show_addr);
        if (int'(mux[d]) != j || led[d] !== byte_of(sw, j)) led_bad++;
        led_n++;
      end
      if (done[d]) begin
        done_s = s;
        break;
      end
      if (!busy[d]) busy_bad++;
      @(negedge clk);
    end
    start[d] = 1'b0;

    check("fill_count", wr_n, DEPTH);
    check("fill_sequence", wr_bad, 0);
    check("din_addr5", wr_din[5], mpat(5, seed_of(d)));
    check("din_addr1", wr_din[1], mpat(1, seed_of(d)));
    check("read_count", rd_n, DEPTH);
    check("read_sequence", rd_bad, 0);
    check("strobe_exclusive", both_hi, 0);
    check("busy_until_done", busy_bad, 0);
    check("done_time", done_s, exp_done);
    check("busy_at_done", busy[d], 1'b0);
    check("err_final", err[d], first_bad >= 0);
    if (first_bad >= 0) begin
      check("err_addr_first", err_addr[d], first_bad);
      check("err_rise_time", err_s, DEPTH + first_bad * pw + 3);
    end else begin
      check("err_never_set", err_s, -1);
    end
    if (show_addr >= 0) begin
      check("led_cycles", led_n, 4 * hold);
      check("led_bytes", led_bad, 0);
    end
    repeat (3) @(negedge clk);
    check("done_held", {done[d], busy[d], mem_write[d], mem_read[d]}, 64'h8);
    check("led_held", led[d], byte_of(stored(d, DEPTH - 1), 3));
  endtask

  task automatic reset_mid_fill(input int d);
    int late_wr;
    late_wr = 0;
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    repeat (30) @(negedge clk);
    check("fill_at_30", {mem_write[d], 2'b00, mem_addr[d]}, {1'b1, 2'b00, 6'd30});
    rst[d] = 1'b1;
    @(negedge clk);
    check_idle_outputs(d, "rst_mid_fill");
    rst[d] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (mem_write[d] || busy[d]) late_wr++;
    end
    check("no_write_after_abort", late_wr, 0);
  endtask

  int lo, fb, k;

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      rst[d] = 1'b1;
      start[d] = 1'b0;
      clear_corr(d);
    end
    repeat (3) @(negedge clk);
    check_idle_outputs(0, "reset0");
    check_idle_outputs(1, "reset1");
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    check_idle_outputs(0, "idle0");

    // Clean pass, start held through the read of word 3 and beyond.
    lo = DEPTH + 3 * (3 + 4 * HOLD0);
    run_once(0, 5, lo, lo + int'($urandom_range(3, 12)));

    // Corrupt word 10 (bit 0) and word 20; first error address must stick at 10.
    corr[0][10] = 32'h0000_0001;
    corr[0][20] = $urandom | 32'h0000_0100;
    run_once(0, 10, -1, -1);

    // Random corruption set, random display word, random ignored start burst.
    clear_corr(0);
    fb = int'($urandom_range(0, DEPTH - 1));
    corr[0][fb] = 32'h1 << $urandom_range(0, 31);
    k = int'($urandom_range(fb, DEPTH - 1));
    corr[0][k] = corr[0][k] | (32'h1 << $urandom_range(0, 31));
    lo = int'($urandom_range(0, 1200));
    run_once(0, int'($urandom_range(0, DEPTH - 1)), lo, lo + int'($urandom_range(1, 20)));

    reset_mid_fill(0);

    // Inverted seed on the second instance with single-cycle byte hold.
    run_once(1, int'($urandom_range(0, DEPTH - 1)), -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
